control_sequencer: RTL and testbench

Instruction-sequencing FSM that produces the per-cycle `control_t` word consumed by the register bank, B bus, barrel shifter, ALU, address and memory modules. Every datapath module decides from this word whether to accept a bus. The block decodes the latched IR, evaluates the condition field against NZCV, and steps through multi-cycle sequences. It also refills the pipeline after reset and after any write to R15.

---
 rtl/control_types_pkg.sv | 55 +++++
 rtl/control_sequencer_if.sv | 22 ++
 rtl/condition_eval.sv | 32 +++
 rtl/control_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/control_types_pkg.sv
// Shared types for the instruction sequencer: the per-cycle control word,
// its field encodings, the sequencer states and the instruction classes.
package control_types_pkg;

    typedef enum logic [1:0] {ADDR_NONE, ADDR_PC, ADDR_ALU} addr_src_t;
    typedef enum logic [2:0] {B_NONE, B_IMM, B_REG_RM, B_REG_RS, B_REG_RD, B_READ_DATA} b_src_t;
    typedef enum logic [1:0] {SHIFT_NONE, SHIFT_IMM, SHIFT_REG} shift_src_t;
    typedef enum logic [1:0] {SHIFT_LSL, SHIFT_LSR, SHIFT_ASR, SHIFT_ROR} shift_type_t;

    // Encoded in ARM data-processing opcode order so ir[24:21] casts directly.
    typedef enum logic [3:0] {
        ALU_AND, ALU_EOR, ALU_SUB, ALU_RSB, ALU_ADD, ALU_ADC, ALU_SBC, ALU_RSC,
        ALU_TST, ALU_TEQ, ALU_CMP, ALU_CMN, ALU_ORR, ALU_MOV, ALU_BIC, ALU_MVN
    } alu_op_t;

    typedef enum logic {WB_NONE, WB_REG_RD} wb_dest_t;

    typedef struct packed {
        addr_src_t   addr_bus_src;
        logic        memory_read_en;
        logic        memory_write_en;
        logic        memory_latch_IR;
        logic        incrementer_writeback;
        b_src_t      B_bus_source;
        logic [11:0] B_bus_imm;
        shift_src_t  shift_source;
        shift_type_t shift_type;
        logic [4:0]  shift_amount;
        logic        latch_shift_amt;
        logic        use_shift_latch;
        alu_op_t     ALU_op;
        logic        ALU_set_flags;
        wb_dest_t    alu_writeback;
        logic        pipeline_flush;
    } control_t;

    // Every enum starts at its NONE/0 member, so all-zero is the idle word.
    localparam control_t CTRL_IDLE = '0;

    typedef enum logic [2:0] {REFILL0, REFILL1, EXEC1, EXEC2, EXEC3} seq_state_t;

    typedef enum logic [2:0] {DP_IMM, DP_REG_IMM, DP_REG_REG, LDR, STR, UNDEF} instr_class_t;

    // Overlay the instruction-fetch fields onto a control word.
    function automatic control_t with_fetch(input control_t c, input logic latch_ir);
        control_t r;
        r = c;
        r.addr_bus_src          = ADDR_PC;
        r.memory_read_en        = 1'b1;
        r.incrementer_writeback = 1'b1;
        r.memory_latch_IR       = latch_ir;
        return r;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the sequencer and the datapath: instruction/flag inputs,
// memory stall, and the control word with its completion strobes.
interface control_sequencer_if;
    import control_types_pkg::*;

    logic [31:0] ir;
    logic [3:0]  flags_nzcv;
    logic        mem_wait;
    control_t    ctrl;
    logic        instr_done;
    logic        undef;

    modport master (
        input  ir, flags_nzcv, mem_wait,
        output ctrl, instr_done, undef
    );

    modport slave (
        output ir, flags_nzcv, mem_wait,
        input  ctrl, instr_done, undef
    );
endinterface

// File: rtl/condition_eval.sv
// ARM condition-code evaluation against the NZCV flags; NV never passes.
module condition_eval (
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       cond_pass
);
    logic n, z, c, v;
    assign {n, z, c, v} = nzcv;

    // Decode all sixteen condition codes.
    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = c;
            4'h3:    cond_pass = !c;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = c && !z;
            4'h9:    cond_pass = !c || z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = !z && (n == v);
            4'hD:    cond_pass = z || (n != v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/control_sequencer.sv
// Instruction-sequencing FSM: decodes the latched IR, checks its condition,
// and emits one control word per cycle, including pipeline refill after
// reset and after any write to R15.
module control_sequencer
    import control_types_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    control_sequencer_if.master bus
);
    seq_state_t   state, state_nx;
    instr_class_t iclass;
    control_t     ctrl_c;
    alu_op_t      alu_op;
    logic         cond_live, cond_held, cond_ok;
    logic         finish, r15_dest;
    logic         done_c, undef_c;
    logic         writes_rd, rd_is_pc;
    logic [3:0]   unused_rn;

    // Rn is consumed by the register bank directly, never by the sequencer.
    assign unused_rn = bus.ir[19:16];
    assign alu_op    = alu_op_t'(bus.ir[24:21]);
    assign writes_rd = !(alu_op inside {ALU_TST, ALU_TEQ, ALU_CMP, ALU_CMN});
    assign rd_is_pc  = (bus.ir[15:12] == 4'hF);

    condition_eval u_cond (
        .cond      (bus.ir[31:28]),
        .nzcv      (bus.flags_nzcv),
        .cond_pass (cond_live)
    );

    // The condition is judged once, in EXEC1; later cycles use the held value.
    assign cond_ok = (state == EXEC1) ? cond_live : cond_held;

    function automatic control_t with_alu(input control_t c, input alu_op_t op,
                                          input logic set_flags, input logic wr);
        control_t r;
        r = c;
        r.ALU_op        = op;
        r.ALU_set_flags = set_flags;
        r.alu_writeback = wr ? WB_REG_RD : WB_NONE;
        return r;
    endfunction

    // Classify the instruction held in IR.
    always_comb begin
        iclass = UNDEF;
        if (bus.ir[27:25] == 3'b001)
            iclass = DP_IMM;
        else if (bus.ir[27:25] == 3'b000 && !bus.ir[4])
            iclass = DP_REG_IMM;
        else if (bus.ir[27:25] == 3'b000 && !bus.ir[7])
            iclass = DP_REG_REG;
        else if (bus.ir[27:26] == 2'b01 && !bus.ir[25] && bus.ir[24] && !bus.ir[22] && !bus.ir[21])
            iclass = bus.ir[20] ? LDR : STR;
    end

    // Next state and the control word for the current cycle.
    always_comb begin
        ctrl_c   = CTRL_IDLE;
        state_nx = state;
        finish   = 1'b0;
        r15_dest = 1'b0;
        done_c   = 1'b0;
        undef_c  = 1'b0;
        case (state)
            REFILL0: begin
                ctrl_c   = with_fetch(CTRL_IDLE, 1'b0);
                state_nx = REFILL1;
            end
            REFILL1: begin
                ctrl_c   = with_fetch(CTRL_IDLE, 1'b1);
                state_nx = EXEC1;
            end
            EXEC1: begin
                if (!cond_ok || iclass == UNDEF) begin
                    finish  = 1'b1;
                    undef_c = (iclass == UNDEF);
                end else begin
                    case (iclass)
                        DP_IMM: begin
                            ctrl_c.B_bus_source = B_IMM;
                            ctrl_c.B_bus_imm    = bus.ir[11:0];
                            ctrl_c.shift_source = SHIFT_IMM;
                            ctrl_c.shift_type   = SHIFT_ROR;
                            ctrl_c.shift_amount = {bus.ir[11:8], 1'b0};
                            ctrl_c   = with_alu(ctrl_c, alu_op, bus.ir[20], writes_rd);
                            finish   = 1'b1;
                            r15_dest = writes_rd && rd_is_pc;
                        end
                        DP_REG_IMM: begin
                            ctrl_c.B_bus_source = B_REG_RM;
                            ctrl_c.shift_source = SHIFT_IMM;
                            ctrl_c.shift_type   = shift_type_t'(bus.ir[6:5]);
                            ctrl_c.shift_amount = bus.ir[11:7];
                            ctrl_c   = with_alu(ctrl_c, alu_op, bus.ir[20], writes_rd);
                            finish   = 1'b1;
                            r15_dest = writes_rd && rd_is_pc;
                        end
                        DP_REG_REG: begin
                            ctrl_c.B_bus_source    = B_REG_RS;
                            ctrl_c.latch_shift_amt = 1'b1;
                            state_nx = EXEC2;
                        end
                        default: begin
                            ctrl_c.B_bus_source   = B_IMM;
                            ctrl_c.B_bus_imm      = bus.ir[11:0];
                            ctrl_c.ALU_op         = bus.ir[23] ? ALU_ADD : ALU_SUB;
                            ctrl_c.addr_bus_src   = ADDR_ALU;
                            ctrl_c.memory_read_en = 1'b1;
                            state_nx = EXEC2;
                        end
                    endcase
                end
            end
            EXEC2: begin
                if (!cond_ok) begin
                    finish = 1'b1;
                end else begin
                    case (iclass)
                        DP_REG_REG: begin
                            ctrl_c.B_bus_source    = B_REG_RM;
                            ctrl_c.shift_source    = SHIFT_REG;
                            ctrl_c.use_shift_latch = 1'b1;
                            ctrl_c.shift_type      = shift_type_t'(bus.ir[6:5]);
                            ctrl_c   = with_alu(ctrl_c, alu_op, bus.ir[20], writes_rd);
                            finish   = 1'b1;
                            r15_dest = writes_rd && rd_is_pc;
                        end
                        LDR: begin
                            ctrl_c.B_bus_source = B_READ_DATA;
                            ctrl_c   = with_alu(ctrl_c, ALU_MOV, 1'b0, 1'b1);
                            finish   = 1'b1;
                            r15_dest = rd_is_pc;
                        end
                        STR: begin
                            // Address register keeps the EXEC1 address.
                            ctrl_c.B_bus_source    = B_REG_RD;
                            ctrl_c.memory_write_en = 1'b1;
                            state_nx = EXEC3;
                        end
                        default: finish = 1'b1;
                    endcase
                end
            end
            EXEC3: finish = 1'b1;
            default: state_nx = REFILL0;
        endcase

        if (finish) begin
            done_c = 1'b1;
            if (r15_dest) begin
                ctrl_c.pipeline_flush = 1'b1;
                state_nx = REFILL0;
            end else begin
                ctrl_c   = with_fetch(ctrl_c, 1'b1);
                state_nx = EXEC1;
            end
        end
    end

    // State register; a memory stall freezes the sequence in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= REFILL0;
        else if (!bus.mem_wait)
            state <= state_nx;
    end

    // Hold the EXEC1 condition result for the remaining cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cond_held <= 1'b0;
        else if (!bus.mem_wait && state == EXEC1)
            cond_held <= cond_live;
    end

    assign bus.ctrl       = ctrl_c;
    assign bus.instr_done = done_c && !bus.mem_wait;
    assign bus.undef      = undef_c && !bus.mem_wait;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed instructions followed by random
// ones, compared cycle by cycle against a per-instruction sequence model.
module tb_control_sequencer;
    import control_types_pkg::*;

    localparam int K_DPI = 0, K_DPR = 1, K_DPRR = 2, K_LDR = 3, K_STR = 4, K_UND = 5;

    typedef struct {
        control_t c;
        bit       done;
        bit       und;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    control_sequencer_if bus();

    control_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s ir=%h observed=%h expected=%h t=%0t", tag, bus.ir, obs, exp, $time);
        end
    endtask

    // Condition as "base test, inverted by the low bit"; 1111 never passes.
    function automatic bit ref_cond(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, c, v, base;
        {n, z, c, v} = f;
        if (cc == 4'hF) return 1'b0;
        case (cc[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return base ^ cc[0];
    endfunction

    function automatic int classify(input logic [31:0] ir);
        if (ir[27:25] == 3'b001) return K_DPI;
        if (ir[27:25] == 3'b000 && ir[4] == 1'b0) return K_DPR;
        if (ir[27:25] == 3'b000 && ir[7] == 1'b0) return K_DPRR;
        if (ir[27:26] == 2'b01 && ir[25] == 1'b0 && ir[24] == 1'b1 && ir[22] == 1'b0 && ir[21] == 1'b0)
            return ir[20] ? K_LDR : K_STR;
        return K_UND;
    endfunction

    function automatic control_t fetch_w(input control_t w, input bit latch);
        w.addr_bus_src          = ADDR_PC;
        w.memory_read_en        = 1'b1;
        w.incrementer_writeback = 1'b1;
        w.memory_latch_IR       = latch;
        return w;
    endfunction

    task automatic push(input control_t c, input bit d, input bit u);
        exp_t e;
        e.c = c; e.done = d; e.und = u;
        exp_q.push_back(e);
    endtask

    task automatic push_refill();
        push(fetch_w('0, 1'b0), 1'b0, 1'b0);
        push(fetch_w('0, 1'b1), 1'b0, 1'b0);
    endtask

    task automatic push_final(input control_t w, input bit to_pc);
        if (to_pc) begin
            w.pipeline_flush = 1'b1;
            push(w, 1'b1, 1'b0);
            push_refill();
        end else begin
            push(fetch_w(w, 1'b1), 1'b1, 1'b0);
        end
    endtask

    // Expected cycle sequence for one instruction, from the instruction rules.
    task automatic build(input logic [31:0] ir, input logic [3:0] f);
        int       kind;
        control_t w;
        bit       wr;
        kind = classify(ir);
        if (kind == K_UND || !ref_cond(ir[31:28], f)) begin
            push(fetch_w('0, 1'b1), 1'b1, kind == K_UND);
            return;
        end
        wr = (ir[24:23] != 2'b10);
        case (kind)
            K_DPI, K_DPR, K_DPRR: begin
                if (kind == K_DPRR) begin
                    w = '0;
                    w.B_bus_source    = B_REG_RS;
                    w.latch_shift_amt = 1'b1;
                    push(w, 1'b0, 1'b0);
                end
                w = '0;
                w.ALU_op        = alu_op_t'(ir[24:21]);
                w.ALU_set_flags = ir[20];
                w.alu_writeback = wr ? WB_REG_RD : WB_NONE;
                if (kind == K_DPI) begin
                    w.B_bus_source = B_IMM;
                    w.B_bus_imm    = ir[11:0];
                    w.shift_source = SHIFT_IMM;
                    w.shift_type   = SHIFT_ROR;
                    w.shift_amount = 5'(ir[11:8]) << 1;
                end else if (kind == K_DPR) begin
                    w.B_bus_source = B_REG_RM;
                    w.shift_source = SHIFT_IMM;
                    w.shift_type   = shift_type_t'(ir[6:5]);
                    w.shift_amount = ir[11:7];
                end else begin
                    w.B_bus_source    = B_REG_RM;
                    w.shift_source    = SHIFT_REG;
                    w.use_shift_latch = 1'b1;
                    w.shift_type      = shift_type_t'(ir[6:5]);
                end
                push_final(w, wr && ir[15:12] == 4'd15);
            end
            default: begin
                w = '0;
                w.B_bus_source   = B_IMM;
                w.B_bus_imm      = ir[11:0];
                w.ALU_op         = ir[23] ? ALU_ADD : ALU_SUB;
                w.addr_bus_src   = ADDR_ALU;
                w.memory_read_en = 1'b1;
                push(w, 1'b0, 1'b0);
                w = '0;
                if (kind == K_LDR) begin
                    w.B_bus_source  = B_READ_DATA;
                    w.ALU_op        = ALU_MOV;
                    w.alu_writeback = WB_REG_RD;
                    push_final(w, ir[15:12] == 4'd15);
                end else begin
                    w.B_bus_source    = B_REG_RD;
                    w.memory_write_en = 1'b1;
                    push(w, 1'b0, 1'b0);
                    push(fetch_w('0, 1'b1), 1'b1, 1'b0);
                end
            end
        endcase
    endtask

    // Consume the expected queue one cycle at a time; called at posedge+1.
    task automatic run_queue(input bit rnd_wait, input logic [15:0] wpat);
        int step   = 0;
        int consec = 0;
        bit first  = 1'b1;
        bit w;
        while (exp_q.size() > 0) begin
            if (rnd_wait) w = (consec < 3) && ($urandom_range(0, 3) == 0);
            else          w = (step < 16) ? wpat[step] : 1'b0;
            bus.mem_wait = w;
            @(negedge clk);
            check("ctrl",  64'(bus.ctrl),       64'(exp_q[0].c));
            check("done",  64'(bus.instr_done), 64'(exp_q[0].done && !w));
            check("undef", 64'(bus.undef),      64'(exp_q[0].und && !w));
            @(posedge clk);
            #1;
            step++;
            if (!w) begin
                void'(exp_q.pop_front());
                consec = 0;
                if (first) begin
                    first = 1'b0;
                    bus.flags_nzcv = 4'($urandom);
                end
            end else begin
                consec++;
            end
        end
        bus.mem_wait = 1'b0;
    endtask

    task automatic run_instr(input logic [31:0] ir, input logic [3:0] f,
                             input bit rnd_wait, input logic [15:0] wpat);
        bus.ir         = ir;
        bus.flags_nzcv = f;
        build(ir, f);
        run_queue(rnd_wait, wpat);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 5);
        if ($urandom_range(0, 1) == 1) r[31:28] = 4'hE;
        case (k)
            0: r[27:25] = 3'b001;
            1: begin r[27:25] = 3'b000; r[4] = 1'b0; end
            2: begin r[27:25] = 3'b000; r[7] = 1'b0; r[4] = 1'b1; end
            3, 4: begin
                r[27:26] = 2'b01; r[25] = 1'b0; r[24] = 1'b1;
                r[22] = 1'b0; r[21] = 1'b0; r[20] = (k == 3);
            end
            default: ;
        endcase
        if ($urandom_range(0, 7) == 0) r[15:12] = 4'hF;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        control_t refill0;
        refill0 = fetch_w('0, 1'b0);
        rst_n          = 1'b1;
        bus.ir         = 32'hE29210FF;
        bus.flags_nzcv = 4'h0;
        bus.mem_wait   = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_ctrl",  64'(bus.ctrl),       64'(refill0));
        check("rst_done",  64'(bus.instr_done), 64'd0);
        check("rst_undef", 64'(bus.undef),      64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        push_refill();
        run_queue(1'b0, 16'h0);

        run_instr(32'hE29210FF, 4'h0, 1'b0, 16'h0);   // ADDS r1,r2,#0xFF
        run_instr(32'hE0810312, 4'h0, 1'b0, 16'h0);   // ADD r0,r1,r2,LSL r3
        run_instr(32'h03510000, 4'h0, 1'b0, 16'h0);   // CMPEQ, Z clear
        run_instr(32'hE1A0F000, 4'h0, 1'b0, 16'h0);   // MOV pc,r0
        run_instr(32'hE5054008, 4'h0, 1'b0, 16'h0006); // STR, two stalls in EXEC2

        // Repeat the STR and pull reset in the middle of EXEC2.
        bus.ir         = 32'hE5054008;
        bus.flags_nzcv = 4'h0;
        bus.mem_wait   = 1'b0;
        @(negedge clk);
        check("str_ex1_addr", 64'(bus.ctrl.addr_bus_src), 64'(ADDR_ALU));
        @(posedge clk);
        #1;
        check("str_ex2_wr", 64'(bus.ctrl.memory_write_en), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ctrl",  64'(bus.ctrl),       64'(refill0));
        check("midrst_done",  64'(bus.instr_done), 64'd0);
        check("midrst_undef", 64'(bus.undef),      64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        push_refill();
        run_queue(1'b0, 16'h0);

        run_instr(32'hE5954004, 4'h0, 1'b0, 16'h0);   // LDR r4,[r5,#4]
        run_instr(32'hEA000000, 4'h0, 1'b0, 16'h0);   // B (unsupported)
        run_instr(32'h0A000000, 4'h0, 1'b0, 16'h0);   // BEQ, failing and unsupported

        for (int i = 0; i < 250; i++)
            run_instr(rand_instr(), 4'($urandom), 1'b1, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
